pmem_arbiter: RTL and testbench

Parametrised N-channel arbiter that shares the single cache-line physical-memory port among several line-granular requesters, e.g. split I-cache/D-cache, plus a future prefetcher or victim buffer. It sits between the caches and the pmem interface, in the place where one cache previously connected to pmem directly. Arbitration is round-robin, one whole-line transaction at a time. Requester-side and pmem-side handshakes are the same read/write/resp protocol the caches already use.

---
 rtl/pmem_arbiter_pkg.sv | 22 ++
 rtl/pmem_arbiter_if.sv | 45 ++++
 rtl/pmem_arbiter_rr_picker.sv | 39 +++
 rtl/pmem_arbiter.sv | 106 ++++++++++
 tb/tb_pmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_pkg
//  Description : Shared types and helpers for the cache-line pmem arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pmem_arbiter_pkg;

    // Arbiter sequencing: grant in IDLE, hold in BUSY, one-cycle completion in DONE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Width of a channel index; never narrower than one bit so N_CH=1 still has a register
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_if
//  Description : Requester-side and pmem-side line handshakes of the arbiter.
//                The master side is the caches plus the memory; the slave
//                side is the arbiter itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pmem_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // requester side
    logic [N_CH-1:0]        ch_read;
    logic [N_CH-1:0]        ch_write;
    logic [N_CH*ADDR_W-1:0] ch_address;
    logic [N_CH*LINE_W-1:0] ch_wdata;
    logic [N_CH-1:0]        ch_resp;
    logic [LINE_W-1:0]      ch_rdata;

    // memory side
    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_W-1:0]      pmem_address;
    logic [LINE_W-1:0]      pmem_wdata;
    logic                   pmem_resp;
    logic [LINE_W-1:0]      pmem_rdata;

    modport master (
        output ch_read, ch_write, ch_address, ch_wdata,
        input  ch_resp, ch_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );

    modport slave (
        input  ch_read, ch_write, ch_address, ch_wdata,
        output ch_resp, ch_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/pmem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_rr_picker
//  Description : Combinational round-robin selector. Returns the first set
//                request scanning ptr, ptr+1, ... modulo N_CH.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter_rr_picker
    import pmem_arbiter_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CH_IDX_W = ch_idx_w(N_CH)
) (
    input  wire logic [N_CH-1:0]     req,
    input  wire logic [CH_IDX_W-1:0] ptr,
    output logic                     found,
    output logic [CH_IDX_W-1:0]      idx
);

    logic [CH_IDX_W:0] w_pos;

    // Walk from the farthest offset to the nearest so the channel closest to ptr writes idx last
    always_comb begin
        found = |req;
        idx   = '0;
        w_pos = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (CH_IDX_W + 1)'(k);
            if (w_pos >= (CH_IDX_W + 1)'(N_CH)) begin
                w_pos = w_pos - (CH_IDX_W + 1)'(N_CH);
            end
            if (req[w_pos[CH_IDX_W-1:0]]) begin
                idx = w_pos[CH_IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : N-channel round-robin arbiter sharing one cache-line pmem
//                port. One whole-line transaction at a time; all outputs
//                are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input wire logic      clk,
    input wire logic      rst,
    pmem_arbiter_if.slave bus
);

    localparam int                  CH_IDX_W  = ch_idx_w(N_CH);
    localparam logic [CH_IDX_W-1:0] c_LAST_CH = CH_IDX_W'(N_CH - 1);

    arb_state_t           r_state;
    logic [CH_IDX_W-1:0]  r_rr_ptr;
    logic [CH_IDX_W-1:0]  r_grant;
    logic [N_CH-1:0]      r_ch_resp;
    logic [LINE_W-1:0]    r_ch_rdata;
    logic                 r_pmem_read;
    logic                 r_pmem_write;
    logic [ADDR_W-1:0]    r_pmem_address;
    logic [LINE_W-1:0]    r_pmem_wdata;

    logic [N_CH-1:0]      w_req;
    logic                 w_found;
    logic [CH_IDX_W-1:0]  w_idx;

    assign w_req = bus.ch_read | bus.ch_write;

    pmem_arbiter_rr_picker #(
        .N_CH     (N_CH),
        .CH_IDX_W (CH_IDX_W)
    ) u_picker (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Arbitration FSM and the latched request/response datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_ch_resp      <= '0;
            r_ch_rdata     <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            // completion is a single-cycle pulse; only the BUSY exit raises it
            r_ch_resp <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant        <= w_idx;
                        r_pmem_address <= bus.ch_address[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_pmem_wdata   <= bus.ch_wdata[int'(w_idx)*LINE_W +: LINE_W];
                        // a channel asserting both is illegal; write takes precedence
                        r_pmem_write   <= bus.ch_write[w_idx];
                        r_pmem_read    <= ~bus.ch_write[w_idx];
                        r_state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.pmem_resp) begin
                        r_ch_rdata   <= bus.pmem_rdata;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_rr_ptr     <= (r_grant == c_LAST_CH) ? '0 : r_grant + 1'b1;
                        r_ch_resp    <= N_CH'(1) << r_grant;
                        r_state      <= DONE;
                    end
                end
                // gives the requester one edge to drop its request before IDLE looks again
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ch_resp      = r_ch_resp;
    assign bus.ch_rdata     = r_ch_rdata;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_arbiter
//  Description : Self-checking bench for pmem_arbiter (2- and 4-channel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam logic [LW-1:0] A5 = {32{8'hA5}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.N_CH(2), .ADDR_W(AW), .LINE_W(LW)) b2 ();
    pmem_arbiter_if #(.N_CH(4), .ADDR_W(AW), .LINE_W(LW)) b4 ();

    pmem_arbiter #(.N_CH(2), .ADDR_W(AW), .LINE_W(LW)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    pmem_arbiter #(.N_CH(4), .ADDR_W(AW), .LINE_W(LW)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

    int n_checks = 0;
    int n_errors = 0;

    // A requester asserting read and write together is a protocol violation
    always @(posedge clk) begin
        if (!rst) begin
            assert ((b2.ch_read & b2.ch_write) == 2'b00) else $error("FAIL illegal_rw ch2");
            assert ((b4.ch_read & b4.ch_write) == 4'b0000) else $error("FAIL illegal_rw ch4");
        end
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch2(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        b2.ch_read[c]             = rd;
        b2.ch_write[c]            = wr;
        b2.ch_address[c*AW +: AW] = a;
        b2.ch_wdata[c*LW +: LW]   = d;
    endtask

    task automatic set_ch4(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        b4.ch_read[c]             = rd;
        b4.ch_write[c]            = wr;
        b4.ch_address[c*AW +: AW] = a;
        b4.ch_wdata[c*LW +: LW]   = d;
    endtask

    // One transaction on the 2-channel DUT whose requests are already applied; ends in DONE
    task automatic run_txn2(input string tag, input int exp_ch, input bit exp_wr, input logic [AW-1:0] exp_addr,
                            input logic [LW-1:0] exp_wdata, input int lat, input logic [LW-1:0] rdata);
        logic [1:0] strobe;
        strobe = exp_wr ? 2'b10 : 2'b01;
        tick();
        chk($sformatf("%s_strobe", tag), {b2.pmem_write, b2.pmem_read}, strobe);
        chk($sformatf("%s_addr", tag), b2.pmem_address, exp_addr);
        if (exp_wr) chk($sformatf("%s_wdata", tag), b2.pmem_wdata, exp_wdata);
        chk($sformatf("%s_noresp", tag), b2.ch_resp, 2'b00);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk($sformatf("%s_hold", tag), {b2.pmem_write, b2.pmem_read, b2.ch_resp, b2.pmem_address},
                {strobe, 2'b00, exp_addr});
        end
        b2.pmem_resp  = 1'b1;
        b2.pmem_rdata = rdata;
        tick();
        b2.pmem_resp  = 1'b0;
        chk($sformatf("%s_resp", tag), b2.ch_resp, 2'b01 << exp_ch);
        chk($sformatf("%s_strobe_off", tag), {b2.pmem_write, b2.pmem_read}, 2'b00);
        if (!exp_wr) chk($sformatf("%s_rdata", tag), b2.ch_rdata, rdata);
    endtask

    typedef struct {
        logic [1:0]    rd;
        logic [1:0]    wr;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [LW-1:0] d0;
        logic [LW-1:0] d1;
        int            lat;
        logic [LW-1:0] rdata;
        int            exp_ch;
        bit            exp_wr;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
    } vec_t;

    vec_t vecs[7];

    // ---------------- random-phase reference state (4-channel DUT) ----------------
    bit            r_act [4];
    bit            r_wr  [4];
    logic [AW-1:0] r_ad  [4];
    logic [LW-1:0] r_wd  [4];
    int            r_cool[4];
    int            r_wait[4];
    logic [LW-1:0] mem [logic [AW-1:0]];

    // Round-robin rule: first requesting channel at p, p+1, ... modulo 4
    function automatic int rr_pick(input int p);
        for (int k = 0; k < 4; k++) begin
            if (r_act[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        int  ph;
        int  m_ptr;
        int  exp_ch;
        int  cnt;
        int  n_txn;
        bit  resp_drv;
        bit  fair_ok;
        logic [LW-1:0] last_rd;
        logic [1:0]    strobe;

        vecs[0] = '{rd:2'b01, wr:2'b00, a0:32'h0000_1000, a1:32'h0, d0:'0, d1:'0, lat:5, rdata:A5,
                    exp_ch:0, exp_wr:1'b0, exp_addr:32'h0000_1000, exp_wdata:'0};
        vecs[1] = '{rd:2'b01, wr:2'b10, a0:32'h100, a1:32'h200, d0:'0, d1:256'h1234, lat:2, rdata:256'h77,
                    exp_ch:1, exp_wr:1'b1, exp_addr:32'h200, exp_wdata:256'h1234};
        vecs[2] = '{rd:2'b11, wr:2'b00, a0:32'h300, a1:32'h400, d0:'0, d1:'0, lat:0, rdata:256'hBEEF_0002,
                    exp_ch:0, exp_wr:1'b0, exp_addr:32'h300, exp_wdata:'0};
        vecs[3] = '{rd:2'b01, wr:2'b00, a0:32'h500, a1:32'h0, d0:'0, d1:'0, lat:1, rdata:256'hBEEF_0003,
                    exp_ch:0, exp_wr:1'b0, exp_addr:32'h500, exp_wdata:'0};
        vecs[4] = '{rd:2'b10, wr:2'b01, a0:32'h600, a1:32'h700, d0:256'hCAFE, d1:'0, lat:3, rdata:256'hBEEF_0004,
                    exp_ch:1, exp_wr:1'b0, exp_addr:32'h700, exp_wdata:'0};
        vecs[5] = '{rd:2'b00, wr:2'b11, a0:32'h800, a1:32'h900, d0:256'hD0, d1:256'hD1, lat:1, rdata:256'h0,
                    exp_ch:0, exp_wr:1'b1, exp_addr:32'h800, exp_wdata:256'hD0};
        vecs[6] = '{rd:2'b00, wr:2'b10, a0:32'h0, a1:32'hA00, d0:'0, d1:256'hEE, lat:0, rdata:256'h0,
                    exp_ch:1, exp_wr:1'b1, exp_addr:32'hA00, exp_wdata:256'hEE};

        // ---------------- reset ----------------
        rst = 1'b1;
        b2.ch_read = '0; b2.ch_write = '0; b2.ch_address = '0; b2.ch_wdata = '0;
        b2.pmem_resp = 1'b0; b2.pmem_rdata = A5;
        b4.ch_read = '0; b4.ch_write = '0; b4.ch_address = '0; b4.ch_wdata = '0;
        b4.pmem_resp = 1'b0; b4.pmem_rdata = A5;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_outs2", {b2.ch_resp, b2.pmem_read, b2.pmem_write, b2.pmem_address}, '0);
        chk("reset_rdata2", b2.ch_rdata, '0);
        chk("reset_wdata2", b2.pmem_wdata, '0);
        chk("reset_outs4", {b4.ch_resp, b4.pmem_read, b4.pmem_write, b4.pmem_address, b4.ch_rdata[31:0]}, '0);

        // ---------------- table of single transactions (pointer starts at 0) ----------------
        for (int i = 0; i < 7; i++) begin
            set_ch2(0, vecs[i].rd[0], vecs[i].wr[0], vecs[i].a0, vecs[i].d0);
            set_ch2(1, vecs[i].rd[1], vecs[i].wr[1], vecs[i].a1, vecs[i].d1);
            run_txn2($sformatf("vec%0d", i), vecs[i].exp_ch, vecs[i].exp_wr, vecs[i].exp_addr,
                     vecs[i].exp_wdata, vecs[i].lat, vecs[i].rdata);
            b2.ch_read = '0; b2.ch_write = '0;
            tick();
            chk($sformatf("vec%0d_done_idle", i), {b2.ch_resp, b2.pmem_read, b2.pmem_write}, '0);
        end

        // ---------------- simultaneous read/write, pointer at 0 ----------------
        set_ch2(0, 1'b1, 1'b0, 32'h100, '0);
        set_ch2(1, 1'b0, 1'b1, 32'h200, 256'h1234);
        run_txn2("sim_a", 0, 1'b0, 32'h100, '0, 2, 256'h5A5A);
        set_ch2(0, 1'b0, 1'b0, 32'h100, '0);
        tick();
        chk("sim_done_nogrant", {b2.pmem_read, b2.pmem_write}, 2'b00);
        run_txn2("sim_b", 1, 1'b1, 32'h200, 256'h1234, 1, 256'h0);
        b2.ch_read = '0; b2.ch_write = '0;
        tick();

        // ---------------- continuous requests on both channels ----------------
        set_ch2(0, 1'b1, 1'b0, 32'h1100, '0);
        set_ch2(1, 1'b1, 1'b0, 32'h2200, '0);
        for (int t = 0; t < 6; t++) begin
            run_txn2($sformatf("rr%0d", t), t % 2, 1'b0, (t % 2 == 0) ? 32'h1100 : 32'h2200,
                     '0, t % 3, 256'(t + 16));
            tick();
        end
        b2.ch_read = '0; b2.ch_write = '0;
        tick();

        // ---------------- address change while BUSY ----------------
        set_ch2(0, 1'b1, 1'b0, 32'h100, '0);
        tick();
        chk("latch_addr0", b2.pmem_address, 32'h100);
        b2.ch_address[0 +: AW] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("latch_hold", {b2.pmem_read, b2.pmem_address}, {1'b1, 32'h100});
        end
        b2.pmem_resp = 1'b1; b2.pmem_rdata = 256'h99;
        tick();
        b2.pmem_resp = 1'b0;
        chk("latch_resp", b2.ch_resp, 2'b01);
        b2.ch_read = '0;
        tick();

        // ---------------- reset during BUSY (pointer currently 1) ----------------
        set_ch2(1, 1'b0, 1'b1, 32'h300, 256'hF00D);
        tick();
        chk("rst_pre_write", {b2.pmem_write, b2.pmem_read}, 2'b10);
        tick();
        rst = 1'b1;
        #2;
        chk("rst_async_clear", {b2.pmem_write, b2.pmem_read, b2.pmem_address}, '0);
        b2.ch_read = '0; b2.ch_write = '0;
        tick();
        rst = 1'b0;
        b2.pmem_resp = 1'b1; b2.pmem_rdata = 256'hBAD;
        tick();
        b2.pmem_resp = 1'b0;
        chk("rst_late_resp", {b2.ch_resp, b2.pmem_read, b2.pmem_write, b2.pmem_address}, '0);
        chk("rst_late_rdata", b2.ch_rdata, '0);
        tick();
        chk("rst_late_resp2", b2.ch_resp, 2'b00);
        set_ch2(0, 1'b1, 1'b0, 32'h40, '0);
        set_ch2(1, 1'b1, 1'b0, 32'h80, '0);
        run_txn2("rst_ptr0", 0, 1'b0, 32'h40, '0, 0, 256'h1);
        b2.ch_read = '0;
        tick();

        // ---------------- 4 channels: pointer at 2, requests on 1 and 3 ----------------
        set_ch4(1, 1'b1, 1'b0, 32'h11, '0);
        tick();
        b4.pmem_resp = 1'b1;
        tick();
        b4.pmem_resp = 1'b0;
        chk("n4_setup_resp", b4.ch_resp, 4'b0010);
        b4.ch_read = '0;
        tick();
        set_ch4(1, 1'b1, 1'b0, 32'h21, '0);
        set_ch4(3, 1'b1, 1'b0, 32'h23, '0);
        tick();
        chk("n4_first_addr", {b4.pmem_read, b4.pmem_address}, {1'b1, 32'h23});
        b4.pmem_resp = 1'b1;
        tick();
        b4.pmem_resp = 1'b0;
        chk("n4_first_resp", b4.ch_resp, 4'b1000);
        b4.ch_read[3] = 1'b0;
        tick();
        tick();
        chk("n4_second_addr", {b4.pmem_read, b4.pmem_address}, {1'b1, 32'h21});
        b4.pmem_resp = 1'b1;
        tick();
        b4.pmem_resp = 1'b0;
        chk("n4_second_resp", b4.ch_resp, 4'b0010);
        b4.ch_read = '0;
        tick();
        b4.pmem_resp = 1'b1; b4.pmem_rdata = 256'h5EED;
        tick();
        b4.pmem_resp = 1'b0;
        chk("n4_spurious", {b4.ch_resp, b4.pmem_read, b4.pmem_write}, '0);
        tick();
        chk("n4_spurious2", b4.ch_resp, 4'b0000);

        // ---------------- randomized traffic on 4 channels vs reference model ----------------
        // after the hand sequences: pointer at 2 (last grant was channel 1), DUT idle
        m_ptr    = 2;
        ph       = 0;
        exp_ch   = 0;
        cnt      = 0;
        n_txn    = 0;
        resp_drv = 1'b0;
        fair_ok  = 1'b1;
        last_rd  = b4.ch_rdata;
        strobe   = 2'b00;
        for (int c = 0; c < 4; c++) begin
            r_act[c] = 1'b0; r_wr[c] = 1'b0; r_ad[c] = '0; r_wd[c] = '0; r_cool[c] = 0; r_wait[c] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            // observe what the edge just passed produced
            if (ph == 0) begin
                exp_ch = rr_pick(m_ptr);
                if (exp_ch >= 0) begin
                    strobe = r_wr[exp_ch] ? 2'b10 : 2'b01;
                    chk("rnd_grant", {b4.pmem_write, b4.pmem_read, b4.ch_resp, b4.pmem_address},
                        {strobe, 4'b0000, r_ad[exp_ch]});
                    if (r_wr[exp_ch]) chk("rnd_wdata", b4.pmem_wdata, r_wd[exp_ch]);
                    for (int c = 0; c < 4; c++) begin
                        if (c == exp_ch) r_wait[c] = 0;
                        else if (r_act[c]) r_wait[c]++;
                        if (r_wait[c] > 3) fair_ok = 1'b0;
                    end
                    cnt = $urandom_range(0, 3);
                    n_txn++;
                    ph = 1;
                end else begin
                    chk("rnd_idle", {b4.pmem_write, b4.pmem_read, b4.ch_resp, b4.ch_rdata},
                        {6'b0, last_rd});
                end
            end else if (ph == 1) begin
                if (resp_drv) begin
                    chk("rnd_resp", {b4.pmem_write, b4.pmem_read, b4.ch_resp}, {2'b00, 4'(1 << exp_ch)});
                    chk("rnd_rdata", b4.ch_rdata, last_rd);
                    if (r_wr[exp_ch]) mem[r_ad[exp_ch]] = r_wd[exp_ch];
                    r_act[exp_ch]  = 1'b0;
                    r_cool[exp_ch] = $urandom_range(1, 3);
                    m_ptr = (exp_ch + 1) % 4;
                    ph = 2;
                end else begin
                    chk("rnd_hold", {b4.pmem_write, b4.pmem_read, b4.ch_resp, b4.pmem_address},
                        {strobe, 4'b0000, r_ad[exp_ch]});
                end
            end else begin
                chk("rnd_done", {b4.pmem_write, b4.pmem_read, b4.ch_resp, b4.ch_rdata}, {6'b0, last_rd});
                ph = 0;
            end

            // memory side for the coming edge
            resp_drv     = 1'b0;
            b4.pmem_resp = 1'b0;
            if (ph == 1) begin
                if (cnt == 0) begin
                    resp_drv     = 1'b1;
                    b4.pmem_resp = 1'b1;
                    if (r_wr[exp_ch]) last_rd = rand_line();
                    else if (mem.exists(r_ad[exp_ch])) last_rd = mem[r_ad[exp_ch]];
                    else last_rd = {8{r_ad[exp_ch]}};
                    b4.pmem_rdata = last_rd;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                b4.pmem_resp  = 1'b1;
                b4.pmem_rdata = rand_line();
            end

            // requester side for the coming edge
            for (int c = 0; c < 4; c++) begin
                if (!r_act[c]) begin
                    if (r_cool[c] > 0) r_cool[c]--;
                    else if ($urandom_range(0, 2) == 0) begin
                        r_act[c] = 1'b1;
                        r_wr[c]  = 1'($urandom_range(0, 1));
                        r_ad[c]  = AW'($urandom_range(0, 7)) << 5;
                        r_wd[c]  = rand_line();
                    end
                end
                set_ch4(c, r_act[c] & ~r_wr[c], r_act[c] & r_wr[c], r_ad[c], r_wd[c]);
            end
        end
        chk("rnd_fairness", fair_ok, 1'b1);
        chk("rnd_txn_count", (n_txn > 100), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
